// File: rtl/regfile_writeback.sv
// regfile_writeback
// ----------------------------------------------------------------------------
// Writeback arbiter and pending-register scoreboard in front of the register
// file's single write port. Each cycle it selects one result for a registered
// write. Candidates are a single-cycle ALU result or the head of a small FIFO
// that buffers long-latency (load/multiply) results. A 32-bit pending mask
// tracks issued long-latency destinations so decode can stall on them.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   alu_valid/rd/data        ALU result stream; alu_ready = accepted this cycle
//   lsu_valid/rd/data        long-latency result stream; lsu_ready = FIFO not full
//   issue_valid/rd           long-latency issue; issue_ready = rd not pending
//   query_rd1/2, busy1/2     decode source lookups against the pending mask
//   wb_write/reg/data        registered register-file write port
//   fifo_count               FIFO occupancy
//   fwd1_hit/fwd2_hit        (WB_BYPASS_EN only) query matches the current write
//
// Configuration
//   WB_BYPASS_EN  when defined, a query that matches the write on wb_* this
//                 cycle reports not-busy and raises fwdN_hit, letting decode
//                 take wb_data directly instead of waiting for the commit.
// ----------------------------------------------------------------------------
module regfile_writeback #(
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          alu_valid,
    input  logic [4:0]                    alu_rd,
    input  logic [XLEN-1:0]               alu_data,
    output logic                          alu_ready,
    input  logic                          lsu_valid,
    input  logic [4:0]                    lsu_rd,
    input  logic [XLEN-1:0]               lsu_data,
    output logic                          lsu_ready,
    input  logic                          issue_valid,
    input  logic [4:0]                    issue_rd,
    output logic                          issue_ready,
    input  logic [4:0]                    query_rd1,
    input  logic [4:0]                    query_rd2,
    output logic                          busy1,
    output logic                          busy2,
    output logic                          wb_write,
    output logic [4:0]                    wb_reg,
    output logic [XLEN-1:0]               wb_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef WB_BYPASS_EN
    ,
    output logic                          fwd1_hit,
    output logic                          fwd2_hit
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    // FIFO storage (data path, not reset)
    logic [4:0]      fifo_rd_q   [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_data_q [FIFO_DEPTH];

    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q,  count_d;
    logic [31:0]     pend_q,   pend_d;

    logic            wb_write_q, wb_write_d;
    logic [4:0]      wb_reg_q,   wb_reg_d;
    logic [XLEN-1:0] wb_data_q,  wb_data_d;

    logic            full, empty;
    logic            push, pop, sel_alu;
    logic [4:0]      head_rd;
    logic [XLEN-1:0] head_data;
    logic [31:0]     set_mask, clr_mask;

    always_comb begin
        full      = (count_q == CW'(FIFO_DEPTH));
        empty     = (count_q == '0);
        head_rd   = fifo_rd_q[rd_ptr_q];
        head_data = fifo_data_q[rd_ptr_q];

        // A full FIFO always wins the port so the ALU can never starve it
        // indefinitely; otherwise the ALU has priority and the FIFO fills gaps.
        // lsu_ready is strictly "not full": a full FIFO refuses new results
        // even though its head drains in that same cycle.
        alu_ready = !full;
        lsu_ready = !full;
        sel_alu   = !full && alu_valid;
        pop       = full || (!alu_valid && !empty);
        push      = lsu_valid && !full;

        wb_write_d = 1'b0;
        wb_reg_d   = wb_reg_q;
        wb_data_d  = wb_data_q;
        if (sel_alu) begin
            wb_write_d = (alu_rd != 5'd0);
            wb_reg_d   = alu_rd;
            wb_data_d  = alu_data;
        end else if (pop) begin
            wb_write_d = (head_rd != 5'd0);
            wb_reg_d   = head_rd;
            wb_data_d  = head_data;
        end

        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Bit 0 of the mask can never be set, so x0 is never busy or blocked.
        issue_ready = !pend_q[issue_rd];
        set_mask    = '0;
        clr_mask    = '0;
        if (issue_valid && issue_ready && (issue_rd != 5'd0))
            set_mask = 32'b1 << issue_rd;
        if (pop)
            clr_mask = 32'b1 << head_rd;
        // Clearing at the selection edge means the bit drops exactly when
        // wb_write asserts for the drained entry.
        pend_d = (pend_q & ~clr_mask) | set_mask;
    end

`ifdef WB_BYPASS_EN
    always_comb begin
        fwd1_hit = wb_write_q && (wb_reg_q == query_rd1);
        fwd2_hit = wb_write_q && (wb_reg_q == query_rd2);
        busy1    = pend_q[query_rd1] && !fwd1_hit;
        busy2    = pend_q[query_rd2] && !fwd2_hit;
    end
`else
    always_comb begin
        busy1 = pend_q[query_rd1];
        busy2 = pend_q[query_rd2];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            pend_q     <= '0;
            wb_write_q <= 1'b0;
            wb_reg_q   <= '0;
            wb_data_q  <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            pend_q     <= pend_d;
            wb_write_q <= wb_write_d;
            wb_reg_q   <= wb_reg_d;
            wb_data_q  <= wb_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_q[wr_ptr_q]   <= lsu_rd;
            fifo_data_q[wr_ptr_q] <= lsu_data;
        end
    end

    assign wb_write   = wb_write_q;
    assign wb_reg     = wb_reg_q;
    assign wb_data    = wb_data_q;
    assign fifo_count = count_q;

endmodule
